// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared state encoding and lane geometry for the dot-product sequencer
package mlp_pkg;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac4_chain.sv
// rtl/mac4_chain.sv - combinational 4-lane signed int8 multiply-accumulate chain
module mac4_chain
    import mlp_pkg::*;
#(
    parameter int WIDTH_SUM = 32,
    parameter int WIDTH_A   = 32,
    parameter int WIDTH_B   = 32
) (
    input  logic [WIDTH_SUM-1:0] sum_in,
    input  logic [WIDTH_A-1:0]   a,
    input  logic [WIDTH_B-1:0]   b,
    output logic [WIDTH_SUM-1:0] sum_out
);

    logic        [WIDTH_SUM-1:0] sum_tmp;
    logic signed [2*LANE_W-1:0]  prod;

    // Four cascaded stages: each adds one sign-extended lane product to the running sum
    always_comb begin
        sum_tmp = sum_in;
        prod    = '0;
        for (int i = 0; i < LANES; i++) begin
            prod    = (2*LANE_W)'($signed(a[i*LANE_W +: LANE_W]))
                    * (2*LANE_W)'($signed(b[i*LANE_W +: LANE_W]));
            sum_tmp = sum_tmp + WIDTH_SUM'(prod);
        end
        sum_out = sum_tmp;
    end

endmodule

// File: rtl/mlp_dot_sequencer.sv
// rtl/mlp_dot_sequencer.sv - sequences an N-word int8 dot product with bias and optional ReLU
module mlp_dot_sequencer
    import mlp_pkg::*;
#(
    parameter int WIDTH_SUM = 32,
    parameter int WIDTH_A   = 32,
    parameter int WIDTH_B   = 32,
    parameter int LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic [WIDTH_SUM-1:0] bias,
    input  logic                 relu_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_A-1:0]   in_a,
    input  logic [WIDTH_B-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_SUM-1:0] out_data,
    output logic                 busy
);

    state_t               state;
    logic [WIDTH_SUM-1:0] acc;
    logic [LEN_W-1:0]     cnt;
    logic                 relu_q;
    logic [WIDTH_SUM-1:0] chain_sum;

    function automatic logic [WIDTH_SUM-1:0] relu_sel(input logic [WIDTH_SUM-1:0] v,
                                                      input logic en);
        return (en && v[WIDTH_SUM-1]) ? '0 : v;
    endfunction

    mac4_chain #(
        .WIDTH_SUM (WIDTH_SUM),
        .WIDTH_A   (WIDTH_A),
        .WIDTH_B   (WIDTH_B)
    ) u_chain (
        .sum_in  (acc),
        .a       (in_a),
        .b       (in_b),
        .sum_out (chain_sum)
    );

    // Job FSM; the result register is loaded with the final sum so out_* never sees in_* combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            relu_q    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= bias;
                        cnt    <= len;
                        relu_q <= relu_en;
                        busy   <= 1'b1;
                        if (len != '0) begin
                            state    <= S_RUN;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            out_data  <= relu_sel(bias, relu_en);
                        end
                    end
                end
                S_RUN: begin
                    if (in_valid && in_ready) begin
                        acc <= chain_sum;
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state     <= S_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= relu_sel(chain_sum, relu_q);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_dot_sequencer.sv
// tb/tb_mlp_dot_sequencer.sv - randomized self-checking bench for mlp_dot_sequencer
module tb_mlp_dot_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [31:0] bias;
    logic        relu_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wa[$];
    logic [31:0] wb[$];

    mlp_dot_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: bias plus the signed dot product of all queued words, 32-bit wrap, optional ReLU
    function automatic logic [31:0] model(input logic [31:0] b, input int n, input bit r);
        logic [31:0] s;
        logic [31:0] x;
        logic [31:0] y;
        int p;
        s = b;
        for (int k = 0; k < n; k++) begin
            x = wa[k];
            y = wb[k];
            for (int l = 0; l < 4; l++) begin
                p = int'($signed(x[8*l +: 8])) * int'($signed(y[8*l +: 8]));
                s = s + 32'(p);
            end
        end
        if (r && s[31]) s = 32'd0;
        return s;
    endfunction

    task automatic set_words(input int n, input bit rnd, input logic [31:0] a, input logic [31:0] b);
        wa.delete();
        wb.delete();
        for (int k = 0; k < n; k++) begin
            wa.push_back(rnd ? $urandom : a);
            wb.push_back(rnd ? $urandom : b);
        end
    endtask

    task automatic run_job(input logic [15:0] n, input logic [31:0] b, input bit r,
                           input int gap_pct, input bit gap1, input int hold, input bit poke);
        logic [31:0] exp;
        logic [31:0] held;
        int idx;
        int guard;
        bit gapped;
        idx    = 0;
        guard  = 0;
        gapped = 0;
        exp    = model(b, int'(n), r);
        @(negedge clk);
        start = 1'b1; len = n; bias = b; relu_en = r;
        while (idx < int'(n) && guard < 2000) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
            check("ov_early", out_valid, 1'b0);
            if (guard == 1) check("ready_run", in_ready, 1'b1);
            if (gap1 && idx == 1 && !gapped) begin
                gapped = 1; in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
            end else if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
            end else if (in_ready) begin
                in_valid = 1'b1; in_a = wa[idx]; in_b = wb[idx]; idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        if (guard >= 2000) check("run_timeout", 32'(idx), 32'(n));
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
        check("ov_rise", out_valid, 1'b1);
        check("data", out_data, exp);
        check("busy_done", busy, 1'b1);
        check("ready_done", in_ready, 1'b0);
        held = out_data;
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start = poke; len = 16'($urandom); bias = $urandom;
            in_valid = poke;
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1; start = poke;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        check("ov_drop", out_valid, 1'b0);
        check("busy_idle", busy, 1'b0);
        @(negedge clk);
        check("start_ignored", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; bias = '0; relu_en = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ov", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", out_data, 32'd0);

        set_words(1, 0, 32'h04030201, 32'h01010101);
        check("model_10", model(32'd0, 1, 0), 32'd10);
        run_job(16'd1, 32'd0, 0, 0, 0, 0, 0);

        set_words(2, 0, 32'hFFFFFFFF, 32'h02020202);
        check("model_m11", model(32'd5, 2, 0), 32'hFFFFFFF5);
        run_job(16'd2, 32'd5, 0, 0, 1, 1, 0);
        run_job(16'd2, 32'd5, 1, 0, 1, 0, 0);

        set_words(0, 0, 32'd0, 32'd0);
        run_job(16'd0, 32'h7, 0, 0, 0, 0, 0);

        set_words(1, 0, 32'h00000001, 32'h00000001);
        check("model_wrap", model(32'h7FFFFFFF, 1, 0), 32'h80000000);
        run_job(16'd1, 32'h7FFFFFFF, 0, 0, 0, 5, 1);

        set_words(8, 1, 32'd0, 32'd0);
        @(negedge clk);
        start = 1'b1; len = 16'd8; bias = 32'h1234; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_a = wa[k]; in_b = wb[k];
            @(negedge clk);
        end
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", in_ready, 1'b0);
        check("mid_rst_ov", out_valid, 1'b0);
        check("mid_rst_data", out_data, 32'd0);
        set_words(1, 0, 32'h01020304, 32'h05060708);
        run_job(16'd1, 32'd0, 0, 0, 0, 0, 0);

        for (int j = 0; j < 200; j++) begin
            int n;
            n = int'($urandom_range(0, 20));
            set_words(n, 1, 32'd0, 32'd0);
            run_job(16'(n), $urandom, 1'($urandom), 30, 0,
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
